instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the RISC-V core. It owns the program counter, fetches instructions from instruction memory over a request/grant/response handshake, and presents one instruction at a time to the control path and datapath (`INSTRout` drives `INSTRin`). It advances the PC when the core retires the current instruction, taking the branch/jump target when `PCSrc` is set.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `clk`  in  1: core clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `run`  in  1: fetch enable; no new request is issued while low.
- `retire`  in  1: the core has finished the presented instruction this cycle.
- `PCSrc`  in  1: on retire, 1 selects `PCTarget` and 0 selects `PC`+4.
- `PCTarget`  in  32: branch/jump target.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  32: fetch address; always equal to `PC`.
- `imem_gnt`  in  1: request accepted this cycle.
- `imem_rvalid`  in  1: read data valid.
- `imem_rdata`  in  32: instruction word.
- `INSTRout`  out  32: registered current instruction.
- `PC`  out  32: address of the current instruction.
- `PCPlus4`  out  32: `PC`+4, modulo 2^32.
- `instr_valid`  out  1: `INSTRout` holds a fetched, unretired instruction.
- `fetch_err`  out  1: sticky misaligned-target flag.
- `retired_count`  out  32: number of retired instructions; wraps.

## Operation
- **Reset values:**
  - `PC` = `RESET_PC`
  - `INSTRout` = 32'h0000_0013 (NOP)
  - `imem_req`, `instr_valid`, `fetch_err` = 0
  - `retired_count` = 0
  - FSM = IDLE
- **FSM states:** IDLE, REQ, WAIT, VALID, HALT.
- **IDLE:**
  - `run`=1 → REQ.
  - `imem_rvalid` is ignored.
- **REQ:**
  - `imem_req`=1.
  - `imem_addr` stays stable until `imem_gnt`.
  - `imem_gnt`=1 → WAIT.
  - `run` falling while in REQ does not withdraw the request.
- **WAIT:**
  - `imem_rvalid`=1 → capture `imem_rdata` into `INSTRout` and go to VALID.
  - `run` is ignored.
- **VALID:**
  - `instr_valid`=1.
  - `retire`=1 updates the PC: `PC` ← `PCSrc` ? `PCTarget` : `PC`+4.
  - `retire`=1 increments `retired_count`.
  - Next state after retire is REQ if `run`=1, else IDLE.
  - `retire` is ignored in every other state.
- **Misaligned target:** retire with `PCSrc`=1 and `PCTarget[1:0]` ≠ 0:
  - `retired_count` increments.
  - `fetch_err` ← 1.
  - `PC` ← `PCTarget` unchanged.
  - Next state is HALT.
- **HALT:** no requests and `instr_valid`=0. Only reset exits HALT.
- **Stray handshakes:** `imem_rvalid` outside WAIT and `imem_gnt` outside REQ are ignored.
- **Arithmetic:** PC arithmetic is 32-bit unsigned and wraps (32'hFFFF_FFFC + 4 = 0). `retired_count` wraps from 32'hFFFF_FFFF to 0.

## Timing
- **Fastest fetch** (`imem_gnt` in the REQ cycle, `imem_rvalid` the next cycle):
  - cycle 0: REQ
  - cycle 1: WAIT, `rvalid` seen
  - cycle 2: VALID, `instr_valid`=1
- **Throughput:** with `retire` in the first VALID cycle, the minimum is 3 cycles per instruction.
- **Instruction memory:** `imem_rvalid` never arrives in the same cycle as `imem_gnt`. Each grant produces exactly one response.
- **Outputs:** `PC`, `imem_addr` and `PCPlus4` change the cycle after retire. `INSTRout` changes only on capture.
- **Reset mid-operation:** assertion returns the block to IDLE immediately. A response still outstanding is dropped because it arrives outside WAIT.

## Structure
- **Shared package `riscv_pkg`:**
  - `fetch_state_t` enum (IDLE, REQ, WAIT, VALID, HALT)
  - `NOP_INSTR` = 32'h0000_0013
  - `XLEN` = 32
- **Single module:** one state register, PC, instruction and counter registers, plus a combinational next-PC mux. No sub-module is needed.

## Test plan
- **Reset and first fetch:** release `reset` with `run`=1 and a zero-wait memory returning 32'h0050_0093. Required: `imem_addr`=0 on cycle 0, `instr_valid`=1 on cycle 2, `INSTRout`=32'h0050_0093.
- **Sequential retire:** retire 3 instructions with `PCSrc`=0. Required: PC sequence 0 → 4 → 8 → C, `retired_count`=3.
- **Branch:** retire with `PCSrc`=1 and `PCTarget`=32'h0000_0100. Required: next `imem_addr`=32'h100, `PCPlus4`=32'h104.
- **Memory stalls:** hold `imem_gnt` low for 4 cycles, then delay `imem_rvalid` 3 cycles, dropping `run` mid-WAIT. Required: address stable throughout REQ, instruction still delivered, FSM goes to IDLE after retire with no new request.
- **Misaligned target:** retire with `PCTarget`=32'h0000_0102.
  - Required: `fetch_err`=1, HALT state, no further `imem_req`.
  - Required after reset: `fetch_err`=0 and `PC`=`RESET_PC`.
- **Reset mid-WAIT:** assert `reset` while in WAIT, then drive a late `imem_rvalid` after release. Required: `INSTRout` stays NOP, `instr_valid`=0, the next fetch comes from `RESET_PC`.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V core types and constants
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    HALT  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, imem handshake, retire tracking
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            retire,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] INSTRout,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            instr_valid,
  output logic            fetch_err,
  output logic [XLEN-1:0] retired_count
);

  fetch_state_t    state, state_d;
  logic            capture;
  logic            retire_en;
  logic            misaligned;
  logic [XLEN-1:0] next_pc;

  assign PCPlus4    = PC + 32'd4;
  assign imem_addr  = PC;
  assign next_pc    = PCSrc ? PCTarget : PCPlus4;
  assign misaligned = PCSrc && (PCTarget[1:0] != 2'b00);

  always_comb begin
    state_d     = state;
    capture     = 1'b0;
    retire_en   = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      IDLE: if (run) state_d = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          capture = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        instr_valid = 1'b1;
        if (retire) begin
          retire_en = 1'b1;
          if (misaligned) state_d = HALT;
          else            state_d = run ? REQ : IDLE;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      PC            <= RESET_PC;
      INSTRout      <= NOP_INSTR;
      fetch_err     <= 1'b0;
      retired_count <= '0;
    end else begin
      state <= state_d;
      if (capture) INSTRout <= imem_rdata;
      // A misaligned target is still committed so software can see where it went wrong
      if (retire_en) begin
        PC            <= next_pc;
        retired_count <= retired_count + 32'd1;
        if (misaligned) fetch_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        retire;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] INSTRout;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_valid;
  logic        fetch_err;
  logic [31:0] retired_count;

  int errors = 0;
  int checks = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .run(run), .retire(retire), .PCSrc(PCSrc),
    .PCTarget(PCTarget), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .INSTRout(INSTRout), .PC(PC), .PCPlus4(PCPlus4), .instr_valid(instr_valid),
    .fetch_err(fetch_err), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a zero-wait grant/response from REQ and leaves the block in VALID
  task automatic fetch(input logic [31:0] word);
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    step();
    imem_rvalid = 1'b0;
    chk("fetch_valid", {31'd0, instr_valid}, 32'd1);
    chk("fetch_instr", INSTRout, word);
  endtask

  task automatic do_retire(input logic src, input logic [31:0] tgt);
    retire   = 1'b1;
    PCSrc    = src;
    PCTarget = tgt;
    step();
    retire   = 1'b0;
    PCSrc    = 1'b0;
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; retire = 1'b0; PCSrc = 1'b0; PCTarget = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    step();
    step();
    chk("rst_pc", PC, 32'h0);
    chk("rst_instr", INSTRout, 32'h0000_0013);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_count", retired_count, 32'd0);
    chk("rst_pcplus4", PCPlus4, 32'd4);

    // Reset release and fastest fetch
    run = 1'b1;
    reset = 1'b1;
    step();
    chk("c0_req", {31'd0, imem_req}, 32'd1);
    chk("c0_addr", imem_addr, 32'h0);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("c1_valid", {31'd0, instr_valid}, 32'd0);
    chk("c1_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    step();
    imem_rvalid = 1'b0;
    chk("c2_valid", {31'd0, instr_valid}, 32'd1);
    chk("c2_instr", INSTRout, 32'h0050_0093);

    // Sequential retire
    do_retire(1'b0, 32'h0);
    chk("seq_pc4", PC, 32'h4);
    chk("seq_req4", {31'd0, imem_req}, 32'd1);
    fetch(32'h0010_0113);
    do_retire(1'b0, 32'h0);
    chk("seq_pc8", imem_addr, 32'h8);
    fetch(32'h0020_0193);
    do_retire(1'b0, 32'h0);
    chk("seq_pcC", PC, 32'hC);
    chk("seq_count", retired_count, 32'd3);

    // Branch
    fetch(32'h1000_006F);
    do_retire(1'b1, 32'h0000_0100);
    chk("br_addr", imem_addr, 32'h100);
    chk("br_pcplus4", PCPlus4, 32'h104);
    chk("br_count", retired_count, 32'd4);

    // Grant stall, address must hold
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, 32'h100);
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    // Response stall with run dropped mid-WAIT
    for (int i = 0; i < 3; i++) begin
      if (i == 1) run = 1'b0;
      step();
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      chk("wait_req", {31'd0, imem_req}, 32'd0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0030_0213;
    step();
    imem_rvalid = 1'b0;
    chk("late_instr", INSTRout, 32'h0030_0213);
    chk("late_valid", {31'd0, instr_valid}, 32'd1);
    do_retire(1'b0, 32'h0);
    chk("idle_pc", PC, 32'h104);
    chk("idle_count", retired_count, 32'd5);
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    // Stray response while IDLE must not be captured
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk("stray_instr", INSTRout, 32'h0030_0213);
    chk("stray_req", {31'd0, imem_req}, 32'd0);
    chk("stray_valid", {31'd0, instr_valid}, 32'd0);
    run = 1'b1;
    step();
    chk("resume_req", {31'd0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'h104);

    // Misaligned target
    fetch(32'h0000_0067);
    do_retire(1'b1, 32'h0000_0102);
    chk("mis_err", {31'd0, fetch_err}, 32'd1);
    chk("mis_pc", PC, 32'h102);
    chk("mis_count", retired_count, 32'd6);
    for (int i = 0; i < 3; i++) begin
      imem_gnt = 1'b1;
      step();
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_gnt = 1'b0;
    reset = 1'b0;
    #1;
    chk("mis_rst_err", {31'd0, fetch_err}, 32'd0);
    chk("mis_rst_pc", PC, 32'h0);
    chk("mis_rst_count", retired_count, 32'd0);
    step();

    // Reset while WAIT, late response afterwards
    reset = 1'b1;
    step();
    chk("rw_req", {31'd0, imem_req}, 32'd1);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("rw_inwait", {31'd0, imem_req}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rw_rst_instr", INSTRout, 32'h0000_0013);
    reset = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hCAFE_F00D;
    step();
    imem_rvalid = 1'b0;
    chk("rw_instr", INSTRout, 32'h0000_0013);
    chk("rw_valid", {31'd0, instr_valid}, 32'd0);
    chk("rw_req2", {31'd0, imem_req}, 32'd1);
    chk("rw_addr", imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
